// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared segment constants, hex glyph table and anode patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int MAX_DIGITS = 32;

    // Segment order is {g,f,e,d,c,b,a}; glyphs are active-high.
    localparam logic [6:0]            SEG_BLANK = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        return glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_hex_decoder
// Description : Combinational hex nibble to active-high {g..a} segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_glyph(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seven_seg_pwm_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pwm_scanner
// Description : Multiplexed common-anode seven-segment driver with PWM
//               brightness, blanking, leading-zero suppression and
//               frame-synchronous input snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_pwm_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 8,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    div_clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] c_anode_off = ANODE_OFF[NUM_DIGITS-1:0];

    logic [PRE_W-1:0]        r_pre;
    logic [BRIGHT_W-1:0]     r_sub;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_dig;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_lz;
    logic [BRIGHT_W-1:0]     r_bright;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic                    w_pre_tc;
    logic                    w_sub_tc;
    logic                    w_idx_tc;
    logic                    w_load;
    logic [4*NUM_DIGITS-1:0] w_dig;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_lz;
    logic [BRIGHT_W-1:0]     w_bright;
    logic [NUM_DIGITS-1:0]   w_lz_dark;
    logic [3:0]              w_nibble;
    logic                    w_blank_sel;
    logic                    w_lzd_sel;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_anode_on;
    logic [6:0]              w_glyph;
    logic                    w_lit;

    assign w_pre_tc = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_sub_tc = &r_sub;
    assign w_idx_tc = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_load   = enable && (r_pre == '0) && (r_sub == '0) && (r_idx == '0);

    // Bypass the snapshot on the load cycle so slot 0 of a frame already
    // shows the freshly captured values instead of the previous frame's.
    assign w_dig    = w_load ? digits      : r_dig;
    assign w_dp     = w_load ? dp          : r_dp;
    assign w_blank  = w_load ? blank       : r_blank;
    assign w_lz     = w_load ? lz_suppress : r_lz;
    assign w_bright = w_load ? bright      : r_bright;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == 0) begin : g_lsd
            assign w_lz_dark[i] = 1'b0;
        end else begin : g_upper
            assign w_lz_dark[i] = w_lz && (w_dig[4*NUM_DIGITS-1:4*i] == '0);
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_blank_sel = 1'b1;
        w_lzd_sel   = 1'b0;
        w_dp_sel    = 1'b0;
        w_anode_on  = c_anode_off;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble      = w_dig[4*i +: 4];
                w_blank_sel   = w_blank[i];
                w_lzd_sel     = w_lz_dark[i];
                w_dp_sel      = w_dp[i];
                w_anode_on[i] = 1'b0;
            end
        end
    end

    seven_seg_hex_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    assign w_lit = enable && !w_blank_sel && !w_lzd_sel && (r_sub <= w_bright);

    always_ff @(posedge div_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre         <= '0;
            r_sub         <= '0;
            r_idx         <= '0;
            r_dig         <= '0;
            r_dp          <= '0;
            r_blank       <= '1;
            r_lz          <= 1'b0;
            r_bright      <= '0;
            r_anode       <= c_anode_off;
            r_seg         <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (enable) begin
                if (w_pre_tc) begin
                    r_pre <= '0;
                    if (w_sub_tc) begin
                        r_sub <= '0;
                        r_idx <= w_idx_tc ? '0 : r_idx + IDX_W'(1);
                    end else begin
                        r_sub <= r_sub + BRIGHT_W'(1);
                    end
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
            if (w_load) begin
                r_dig    <= digits;
                r_dp     <= dp;
                r_blank  <= blank;
                r_lz     <= lz_suppress;
                r_bright <= bright;
            end
            if (w_lit) begin
                r_anode <= w_anode_on;
                r_seg   <= ~w_glyph;
                r_dp_n  <= ~w_dp_sel;
            end else begin
                r_anode <= c_anode_off;
                r_seg   <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end
        end
    end

    assign anode       = r_anode;
    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
